// File: rtl/time_set_entry_if.sv
// Button, current-time and load-port bundle between the front panel editor
// and its surroundings (buttons/clock on the master side, editor on the slave side).
interface time_set_entry_if;
    logic       btn_time;
    logic       btn_alarm;
    logic       btn_up;
    logic       btn_next;
    logic       btn_ok;
    logic [1:0] cur_h1;
    logic [3:0] cur_h0;
    logic [3:0] cur_m1;
    logic [3:0] cur_m0;
    logic [1:0] H_in1;
    logic [3:0] H_in0;
    logic [3:0] M_in1;
    logic [3:0] M_in0;
    logic       LD_time;
    logic       LD_alarm;
    logic       editing;
    logic [1:0] edit_digit;

    modport master (
        output btn_time, btn_alarm, btn_up, btn_next, btn_ok,
        output cur_h1, cur_h0, cur_m1, cur_m0,
        input  H_in1, H_in0, M_in1, M_in0,
        input  LD_time, LD_alarm, editing, edit_digit
    );

    modport slave (
        input  btn_time, btn_alarm, btn_up, btn_next, btn_ok,
        input  cur_h1, cur_h0, cur_m1, cur_m0,
        output H_in1, H_in0, M_in1, M_in0,
        output LD_time, LD_alarm, editing, edit_digit
    );
endinterface

// File: rtl/time_set_entry.sv
// Front panel editor: composes a valid 24-hour HH:MM digit by digit from button
// presses and strobes it into the clock's time or alarm load port.
module time_set_entry #(
    parameter int LD_HOLD = 12,
    parameter int TIMEOUT = 1000
) (
    input  logic            clk,
    input  logic            reset,
    time_set_entry_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        EDIT_H1 = 3'd1,
        EDIT_H0 = 3'd2,
        EDIT_M1 = 3'd3,
        EDIT_M0 = 3'd4,
        LOAD    = 3'd5
    } state_t;

    localparam int TO_W   = $clog2(TIMEOUT + 1);
    localparam int LD_W   = $clog2(LD_HOLD + 1);
    localparam int B_OK    = 0;
    localparam int B_NEXT  = 1;
    localparam int B_UP    = 2;
    localparam int B_ALARM = 3;
    localparam int B_TIME  = 4;

    state_t          state_q, state_d;
    logic [4:0]      btn_prev_q, btn_prev_d;
    logic [4:0]      btn_now, press;
    logic            target_alarm_q, target_alarm_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [LD_W-1:0] ld_cnt_q, ld_cnt_d;
    logic [1:0]      h1_q, h1_d;
    logic [3:0]      h0_q, h0_d;
    logic [3:0]      m1_q, m1_d;
    logic [3:0]      m0_q, m0_d;
    logic            editing_q, editing_d;
    logic [1:0]      edit_digit_q, edit_digit_d;
    logic            ld_time_q, ld_time_d;
    logic            ld_alarm_q, ld_alarm_d;

    function automatic logic [3:0] wrap_inc(input logic [3:0] v, input logic [3:0] top);
        return (v >= top) ? 4'd0 : v + 4'd1;
    endfunction

    function automatic logic is_edit(input state_t s);
        return (s == EDIT_H1) || (s == EDIT_H0) || (s == EDIT_M1) || (s == EDIT_M0);
    endfunction

    function automatic logic [1:0] digit_of(input state_t s);
        case (s)
            EDIT_H0: return 2'd1;
            EDIT_M1: return 2'd2;
            EDIT_M0: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic state_t next_digit(input state_t s);
        case (s)
            EDIT_H1: return EDIT_H0;
            EDIT_H0: return EDIT_M1;
            EDIT_M1: return EDIT_M0;
            default: return EDIT_H1;
        endcase
    endfunction

    assign btn_now = {bus.btn_time, bus.btn_alarm, bus.btn_up, bus.btn_next, bus.btn_ok};
    assign press   = btn_now & ~btn_prev_q;

    always_comb begin
        state_d        = state_q;
        btn_prev_d     = btn_now;
        target_alarm_d = target_alarm_q;
        to_cnt_d       = to_cnt_q;
        ld_cnt_d       = ld_cnt_q;
        h1_d           = h1_q;
        h0_d           = h0_q;
        m1_d           = m1_q;
        m0_d           = m0_q;

        case (state_q)
            IDLE: begin
                to_cnt_d = '0;
                if (press[B_TIME] || press[B_ALARM]) begin
                    state_d        = EDIT_H1;
                    target_alarm_d = ~press[B_TIME];
                    h1_d           = bus.cur_h1;
                    h0_d           = bus.cur_h0;
                    m1_d           = bus.cur_m1;
                    m0_d           = bus.cur_m0;
                end
            end
            EDIT_H1, EDIT_H0, EDIT_M1, EDIT_M0: begin
                if (|press) begin
                    to_cnt_d = '0;
                    if (press[B_OK]) begin
                        state_d  = LOAD;
                        ld_cnt_d = '0;
                    end else if (press[B_NEXT]) begin
                        state_d = next_digit(state_q);
                    end else if (press[B_UP]) begin
                        case (state_q)
                            EDIT_H1: begin
                                h1_d = (h1_q >= 2'd2) ? 2'd0 : h1_q + 2'd1;
                                // Stepping into the 20s must not leave an hour above 23.
                                if (h1_q == 2'd1 && h0_q > 4'd3) h0_d = 4'd3;
                            end
                            EDIT_H0: h0_d = wrap_inc(h0_q, (h1_q == 2'd2) ? 4'd3 : 4'd9);
                            EDIT_M1: m1_d = wrap_inc(m1_q, 4'd5);
                            default: m0_d = wrap_inc(m0_q, 4'd9);
                        endcase
                    end
                end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    state_d  = IDLE;
                    to_cnt_d = '0;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            LOAD: begin
                if (ld_cnt_q == LD_W'(LD_HOLD - 1)) begin
                    state_d = IDLE;
                end else begin
                    ld_cnt_d = ld_cnt_q + LD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        editing_d    = is_edit(state_d);
        edit_digit_d = digit_of(state_d);
        ld_time_d    = (state_d == LOAD) && !target_alarm_d;
        ld_alarm_d   = (state_d == LOAD) && target_alarm_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            btn_prev_q     <= '1;
            target_alarm_q <= 1'b0;
            to_cnt_q       <= '0;
            ld_cnt_q       <= '0;
            h1_q           <= '0;
            h0_q           <= '0;
            m1_q           <= '0;
            m0_q           <= '0;
            editing_q      <= 1'b0;
            edit_digit_q   <= '0;
            ld_time_q      <= 1'b0;
            ld_alarm_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            btn_prev_q     <= btn_prev_d;
            target_alarm_q <= target_alarm_d;
            to_cnt_q       <= to_cnt_d;
            ld_cnt_q       <= ld_cnt_d;
            h1_q           <= h1_d;
            h0_q           <= h0_d;
            m1_q           <= m1_d;
            m0_q           <= m0_d;
            editing_q      <= editing_d;
            edit_digit_q   <= edit_digit_d;
            ld_time_q      <= ld_time_d;
            ld_alarm_q     <= ld_alarm_d;
        end
    end

    assign bus.H_in1      = h1_q;
    assign bus.H_in0      = h0_q;
    assign bus.M_in1      = m1_q;
    assign bus.M_in0      = m0_q;
    assign bus.LD_time    = ld_time_q;
    assign bus.LD_alarm   = ld_alarm_q;
    assign bus.editing    = editing_q;
    assign bus.edit_digit = edit_digit_q;
endmodule

// File: tb/tb_time_set_entry.sv
// Bench for time_set_entry: directed panel sequences plus random button traffic,
// scored against a behavioural model of the editor through expectation queues.
module tb_time_set_entry;
    localparam int LD_HOLD = 12;
    localparam int TIMEOUT = 20;
    localparam logic [4:0] B_OK    = 5'b00001;
    localparam logic [4:0] B_NEXT  = 5'b00010;
    localparam logic [4:0] B_UP    = 5'b00100;
    localparam logic [4:0] B_ALARM = 5'b01000;
    localparam logic [4:0] B_TIME  = 5'b10000;

    typedef struct packed {
        logic       editing;
        logic [1:0] sel;
        logic [1:0] h1;
        logic [3:0] h0;
        logic [3:0] m1;
        logic [3:0] m0;
        logic       ldt;
        logic       lda;
    } snap_t;

    typedef struct packed {
        logic       alarm;
        logic [1:0] h1;
        logic [3:0] h0;
        logic [3:0] m1;
        logic [3:0] m0;
    } commit_t;

    logic clk;
    logic reset;
    time_set_entry_if bus();

    time_set_entry #(.LD_HOLD(LD_HOLD), .TIMEOUT(TIMEOUT)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    snap_t   exp_q[$];
    commit_t commit_q[$];
    int      n_compared = 0;
    int      n_failed   = 0;

    // Behavioural model: mode 0 idle, 1 editing, 2 loading.
    int         m_mode = 0;
    int         m_sel = 0;
    int         m_quiet = 0;
    int         m_ld_left = 0;
    bit         m_alarm = 0;
    int         m_d[4] = '{0, 0, 0, 0};
    logic [4:0] m_prev = '1;

    function automatic void bump(input int sel);
        case (sel)
            0: begin
                m_d[0] = (m_d[0] + 1) % 3;
                if (m_d[0] * 10 + m_d[1] > 23) m_d[1] = 3;
            end
            1: m_d[1] = (m_d[1] + 1) % ((m_d[0] == 2) ? 4 : 10);
            2: m_d[2] = (m_d[2] + 1) % 6;
            default: m_d[3] = (m_d[3] + 1) % 10;
        endcase
    endfunction

    task automatic model_edge(input bit rst_v, input logic [4:0] b);
        logic [4:0] pr;
        snap_t      s;
        commit_t    c;
        pr     = b & ~m_prev;
        m_prev = b;
        if (rst_v) begin
            m_mode = 0; m_sel = 0; m_quiet = 0; m_ld_left = 0; m_alarm = 0;
            m_d    = '{0, 0, 0, 0};
            m_prev = '1;
        end else begin
            case (m_mode)
                0: if (pr[4] || pr[3]) begin
                    m_mode = 1; m_sel = 0; m_quiet = 0; m_alarm = !pr[4];
                    m_d[0] = int'(bus.cur_h1); m_d[1] = int'(bus.cur_h0);
                    m_d[2] = int'(bus.cur_m1); m_d[3] = int'(bus.cur_m0);
                end
                1: if (pr != 5'b0) begin
                    m_quiet = 0;
                    if (pr[0]) begin
                        m_mode = 2; m_ld_left = LD_HOLD;
                        c.alarm = m_alarm;
                        c.h1 = 2'(m_d[0]); c.h0 = 4'(m_d[1]); c.m1 = 4'(m_d[2]); c.m0 = 4'(m_d[3]);
                        commit_q.push_back(c);
                    end else if (pr[1]) m_sel = (m_sel + 1) % 4;
                    else if (pr[2]) bump(m_sel);
                end else begin
                    m_quiet++;
                    if (m_quiet == TIMEOUT) m_mode = 0;
                end
                default: begin
                    m_ld_left--;
                    if (m_ld_left == 0) m_mode = 0;
                end
            endcase
        end
        s.editing = (m_mode == 1);
        s.sel = 2'(m_sel);
        s.h1 = 2'(m_d[0]); s.h0 = 4'(m_d[1]); s.m1 = 4'(m_d[2]); s.m0 = 4'(m_d[3]);
        s.ldt = (m_mode == 2) && !m_alarm;
        s.lda = (m_mode == 2) && m_alarm;
        exp_q.push_back(s);
    endtask

    task automatic step(input bit rst_v, input logic [4:0] b);
        reset = rst_v;
        {bus.btn_time, bus.btn_alarm, bus.btn_up, bus.btn_next, bus.btn_ok} = b;
        @(posedge clk);
        model_edge(rst_v, b);
        #1;
    endtask

    task automatic press(input logic [4:0] b);
        step(1'b0, b);
        step(1'b0, 5'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'b0);
    endtask

    task automatic set_cur(input int h1, input int h0, input int m1, input int m0);
        bus.cur_h1 = 2'(h1); bus.cur_h0 = 4'(h0); bus.cur_m1 = 4'(m1); bus.cur_m0 = 4'(m0);
    endtask

    // Monitor: per-cycle output snapshot plus a commit check on every LD strobe rising edge.
    snap_t   mon_a, mon_e;
    commit_t mon_ca, mon_ce;
    bit      ld_prev = 1'b0;
    bit      ld_now;
    always @(negedge clk) begin
        mon_a.editing = bus.editing;
        mon_a.sel = bus.edit_digit;
        mon_a.h1 = bus.H_in1; mon_a.h0 = bus.H_in0; mon_a.m1 = bus.M_in1; mon_a.m0 = bus.M_in0;
        mon_a.ldt = bus.LD_time; mon_a.lda = bus.LD_alarm;
        ld_now = (bus.LD_time === 1'b1) || (bus.LD_alarm === 1'b1);
        if (ld_now && !ld_prev) begin
            n_compared++;
            mon_ca.alarm = bus.LD_alarm;
            mon_ca.h1 = bus.H_in1; mon_ca.h0 = bus.H_in0; mon_ca.m1 = bus.M_in1; mon_ca.m0 = bus.M_in0;
            if (commit_q.size() == 0) begin
                n_failed++;
                $display("FAIL commit t=%0t: load strobe seen with value %h, required no load", $time, mon_ca);
            end else begin
                mon_ce = commit_q.pop_front();
                if (mon_ca !== mon_ce) begin
                    n_failed++;
                    $display("FAIL commit t=%0t: got alarm=%0d %0d%0d:%0d%0d, required alarm=%0d %0d%0d:%0d%0d",
                             $time, mon_ca.alarm, mon_ca.h1, mon_ca.h0, mon_ca.m1, mon_ca.m0,
                             mon_ce.alarm, mon_ce.h1, mon_ce.h0, mon_ce.m1, mon_ce.m0);
                end
            end
        end
        ld_prev = ld_now;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            if (!mon_e.editing) begin
                mon_e.sel = 2'd0;
                mon_a.sel = 2'd0;
            end
            n_compared++;
            if (mon_a !== mon_e) begin
                n_failed++;
                $display("FAIL outputs t=%0t: got ed=%0d sel=%0d %0d%0d:%0d%0d ldt=%0d lda=%0d, required ed=%0d sel=%0d %0d%0d:%0d%0d ldt=%0d lda=%0d",
                         $time, mon_a.editing, mon_a.sel, mon_a.h1, mon_a.h0, mon_a.m1, mon_a.m0, mon_a.ldt, mon_a.lda,
                         mon_e.editing, mon_e.sel, mon_e.h1, mon_e.h0, mon_e.m1, mon_e.m0, mon_e.ldt, mon_e.lda);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, required completion before %0t", $time);
        $fatal(1);
    end

    initial begin
        int h1r;
        logic [4:0] b;
        reset = 1'b1;
        {bus.btn_time, bus.btn_alarm, bus.btn_up, bus.btn_next, bus.btn_ok} = 5'b0;
        set_cur(0, 0, 0, 0);
        step(1'b1, 5'b0);
        step(1'b1, 5'b0);
        idle(2);

        // Edit from the current time 12:34, then commit it.
        set_cur(1, 2, 3, 4);
        press(B_TIME);
        idle(2);
        press(B_OK);
        idle(LD_HOLD + 2);

        // H1 clamp on entering the 20s, then wrap to 0.
        set_cur(1, 9, 0, 5);
        press(B_TIME);
        press(B_UP);
        press(B_UP);
        // Minutes wrap without carry.
        press(B_NEXT);
        press(B_NEXT);
        for (int i = 0; i < 6; i++) press(B_UP);
        press(B_NEXT);
        for (int i = 0; i < 5; i++) press(B_UP);
        press(B_OK);
        idle(LD_HOLD + 2);

        // Alarm edited to 07:45.
        set_cur(0, 0, 0, 0);
        press(B_ALARM);
        press(B_NEXT);
        for (int i = 0; i < 7; i++) press(B_UP);
        press(B_NEXT);
        for (int i = 0; i < 4; i++) press(B_UP);
        press(B_NEXT);
        for (int i = 0; i < 5; i++) press(B_UP);
        press(B_OK);
        idle(LD_HOLD + 3);

        // Held up button, both mode buttons together, and ok+next+up in one cycle.
        press(B_TIME);
        for (int i = 0; i < 50; i++) step(1'b0, B_UP);
        step(1'b0, 5'b0);
        press(B_TIME | B_ALARM);
        press(B_OK | B_NEXT | B_UP);
        idle(LD_HOLD + 2);

        // Timeout, then reset in the middle of a load.
        set_cur(2, 3, 5, 9);
        press(B_ALARM);
        idle(TIMEOUT + 5);
        press(B_TIME);
        press(B_UP);
        step(1'b0, B_OK);
        idle(3);
        step(1'b1, 5'b0);
        idle(3);

        // Random button traffic with occasional resets and new current times.
        for (int n = 0; n < 3000; n++) begin
            if (n % 97 == 0) begin
                h1r = $urandom_range(0, 2);
                set_cur(h1r, (h1r == 2) ? $urandom_range(0, 3) : $urandom_range(0, 9),
                        $urandom_range(0, 5), $urandom_range(0, 9));
            end
            for (int k = 0; k < 5; k++) b[k] = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7) != 0) b[4:3] = b[4:3] & {$urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0};
            step($urandom_range(0, 499) == 0, b);
        end
        idle(LD_HOLD + TIMEOUT + 4);

        @(negedge clk);
        @(negedge clk);
        n_compared++;
        if (exp_q.size() != 0 || commit_q.size() != 0) begin
            n_failed++;
            $display("FAIL drain: got %0d snapshots and %0d commits pending, required 0 and 0",
                     exp_q.size(), commit_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end
endmodule
